// File: rtl/mem_access_unit.sv
// Memory stage: drives the req/gnt/rvalid data bus, formats loads, registers MEM/WB.
// Optional bus timeout abort: define MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] regOp2_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  WriteSrc_i,
  input  logic [31:0] ImmOp_i,
  input  logic [31:0] pcPlus4_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        RegWrite_o,
  output logic [1:0]  WriteSrc_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] ImmOp_o,
  output logic [31:0] pcPlus4_o,
  output logic [4:0]  rd_o,
  output logic [31:0] ReadData_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        access_c;
  logic        bad_f3_c;
  logic        misal_c;
  logic        fault_c;
  logic        start_c;
  logic        done_c;
  logic        timeout_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_fmt_c;
  logic [7:0]  rbyte_c;
  logic [15:0] rhalf_c;

  assign access_c = valid_i & (MemRead_i | MemWrite_i);

  assign bad_f3_c = (funct3_i == 3'b011)
                  | (funct3_i[2:1] == 2'b11)
                  | (funct3_i[2] & MemWrite_i);

  assign misal_c = ((funct3_i[1:0] == 2'b10) & (ALUout_i[1:0] != 2'b00))
                 | ((funct3_i[1:0] == 2'b01) & ALUout_i[0]);

  assign fault_c = access_c & (bad_f3_c | misal_c);
  assign start_c = access_c & ~fault_c & (state_q == IDLE);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = regOp2_i;
    unique case (1'b1)
      funct3_i[1:0] == 2'b00: begin
        be_c    = 4'b0001 << ALUout_i[1:0];
        wdata_c = {4{regOp2_i[7:0]}};
      end
      funct3_i[1:0] == 2'b01: begin
        be_c    = ALUout_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{regOp2_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = regOp2_i;
      end
    endcase
  end

  assign rbyte_c = 8'(mem_rdata_i >> {lane_q, 3'b000});
  assign rhalf_c = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    rdata_fmt_c = mem_rdata_i;
    unique case (1'b1)
      f3_q == 3'b000: rdata_fmt_c = {{24{rbyte_c[7]}}, rbyte_c};
      f3_q == 3'b100: rdata_fmt_c = {24'h0, rbyte_c};
      f3_q == 3'b001: rdata_fmt_c = {{16{rhalf_c[15]}}, rhalf_c};
      f3_q == 3'b101: rdata_fmt_c = {16'h0, rhalf_c};
      default:        rdata_fmt_c = mem_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt_q;
  logic          cnt_hit_c;

  assign cnt_hit_c = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (start_c) begin
      cnt_q <= '0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic cnt_hit_c;
  assign cnt_hit_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          stall_o = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_gnt_i) begin
          if (we_q) begin
            stall_o = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          stall_o = 1'b0;
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An unfinished access that hits the limit is abandoned this cycle
    if ((state_q != IDLE) && stall_o && cnt_hit_c) begin
      mem_req_o = 1'b0;
      stall_o   = 1'b0;
      done_c    = 1'b0;
      timeout_c = 1'b1;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
    end else if (start_c) begin
      we_q    <= MemWrite_i;
      addr_q  <= {ALUout_i[31:2], 2'b00};
      be_q    <= be_c;
      wdata_q <= wdata_c;
      f3_q    <= funct3_i;
      lane_q  <= ALUout_i[1:0];
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      RegWrite_o <= 1'b0;
      WriteSrc_o <= '0;
      ALUout_o   <= '0;
      ImmOp_o    <= '0;
      pcPlus4_o  <= '0;
      rd_o       <= '0;
      ReadData_o <= '0;
      fault_o    <= 1'b0;
    end else if (stall_o) begin
      RegWrite_o <= 1'b0;
      fault_o    <= 1'b0;
    end else begin
      RegWrite_o <= valid_i & RegWrite_i & ~fault_c & ~timeout_c;
      WriteSrc_o <= WriteSrc_i;
      ALUout_o   <= ALUout_i;
      ImmOp_o    <= ImmOp_i;
      pcPlus4_o  <= pcPlus4_i;
      rd_o       <= rd_i;
      ReadData_o <= done_c ? rdata_fmt_c : 32'h0;
      fault_o    <= fault_c | timeout_c;
    end
  end

endmodule
